// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU control unit: registered IF/ID/EXE/MEM/WB/HLT sequencer with
// combinational control decode and a retired-instruction counter.
module mc_control_fsm #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic [3:0]       ALUOp,
  output logic             PCWre,
  output logic             IRWre,
  output logic             RegWre,
  output logic             mRD,
  output logic             mWR,
  output logic             RegDst,
  output logic             DBDataSrc,
  output logic             ExtSel,
  output logic [1:0]       PCSrc,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] StIf  = 3'b000;
  localparam logic [2:0] StId  = 3'b001;
  localparam logic [2:0] StExe = 3'b010;
  localparam logic [2:0] StMem = 3'b011;
  localparam logic [2:0] StWb  = 3'b100;
  localparam logic [2:0] StHlt = 3'b111;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic op_r, op_addi, op_addiu, op_andi, op_ori, op_slti;
  logic op_lw, op_sw, op_beq, op_bne, op_j, op_halt;
  logic op_imm, op_br, op_ill, in_instr;
  logic [3:0] alu_dec;

  always_comb begin
    op_r     = (opcode == 6'b000000);
    op_addi  = (opcode == 6'b001000);
    op_addiu = (opcode == 6'b001001);
    op_andi  = (opcode == 6'b001100);
    op_ori   = (opcode == 6'b001101);
    op_slti  = (opcode == 6'b001010);
    op_lw    = (opcode == 6'b100011);
    op_sw    = (opcode == 6'b101011);
    op_beq   = (opcode == 6'b000100);
    op_bne   = (opcode == 6'b000101);
    op_j     = (opcode == 6'b000010);
    op_halt  = (opcode == 6'b111111);
    op_imm   = op_addi | op_addiu | op_andi | op_ori | op_slti;
    op_br    = op_beq | op_bne;
    op_ill   = ~(op_r | op_imm | op_lw | op_sw | op_br | op_j | op_halt);
  end

  always_comb begin
    alu_dec = 4'b0000;
    if (op_r)         alu_dec = 4'b1000;
    else if (op_andi) alu_dec = 4'b0010;
    else if (op_ori)  alu_dec = 4'b0011;
    else if (op_slti) alu_dec = 4'b0101;
    else if (op_br)   alu_dec = 4'b0001;
  end

  always_comb begin
    state_d = StIf;
    case (state_q)
      StIf:  state_d = StId;
      StId: begin
        if (op_j || op_ill) state_d = StIf;
        else if (op_halt)   state_d = StHlt;
        else                state_d = StExe;
      end
      StExe: begin
        if (op_lw || op_sw)      state_d = StMem;
        else if (op_r || op_imm) state_d = StWb;
        else                     state_d = StIf;
      end
      StMem: state_d = op_lw ? StWb : StIf;
      StWb:  state_d = StIf;
      StHlt: state_d = StHlt;
      default: state_d = StIf;
    endcase
  end

  // PCWre marks the last cycle of a real instruction; IF itself never qualifies.
  assign in_instr = (state_q == StId) || (state_q == StExe) ||
                    (state_q == StMem) || (state_q == StWb);

  // Enables are gated with rst_n so they drop the instant reset asserts.
  always_comb begin
    PCWre     = rst_n & in_instr & (state_d == StIf);
    IRWre     = rst_n & (state_q == StIf);
    RegWre    = rst_n & (state_q == StWb);
    mRD       = rst_n & (state_q == StMem) & op_lw;
    mWR       = rst_n & (state_q == StMem) & op_sw;
    RegDst    = op_r;
    DBDataSrc = op_lw;
    ExtSel    = ~(op_andi | op_ori);
    ALUOp     = ((state_q == StIf) || (state_q == StHlt)) ? 4'b0000 : alu_dec;
    PCSrc     = 2'b00;
    if (rst_n && (state_q == StId) && op_j) begin
      PCSrc = 2'b10;
    end else if (rst_n && (state_q == StExe) && ((op_beq && zero) || (op_bne && !zero))) begin
      PCSrc = 2'b01;
    end
  end

  assign retired_d = PCWre ? retired_q + CNT_W'(1) : retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIf;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter: CNT_W, default 16, width of the retired-instruction counter.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  6  instruction[31:26] from the instruction register.
REQ-005 zero  input  1  ALU zero flag, valid during EXE.
REQ-006 ALUOp  output  4  to ALU-control stage:
- 1000 = R-type (func decode downstream)
- 0000 = add
- 0001 = sub/compare
- 0010 = and
- 0011 = or
- 0101 = set-less-than
REQ-007 PCWre  output  1  PC write enable.
REQ-008 IRWre  output  1  instruction register write enable.
REQ-009 RegWre  output  1  register file write enable.
REQ-010 mRD  output  1  data memory read.
REQ-011 mWR  output  1  data memory write.
REQ-012 RegDst  output  1  1 = rd, 0 = rt.
REQ-013 DBDataSrc  output  1  1 = memory data, 0 = ALU result.
REQ-014 ExtSel  output  1  1 = sign-extend, 0 = zero-extend.
REQ-015 PCSrc  output  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
REQ-016 state  output  3  current state: IF=000, ID=001, EXE=010, MEM=011, WB=100, HLT=111.
REQ-017 retired  output  CNT_W  count of completed instructions.

Function
REQ-018 The FSM state SHALL be registered; all control outputs SHALL decode combinationally from state and opcode.
REQ-019 Supported opcodes: R=000000, addi=001000, addiu=001001, andi=001100, ori=001101, slti=001010, lw=100011, sw=101011, beq=000100, bne=000101, j=000010, halt=111111.
REQ-020 Any other opcode is illegal and SHALL be treated as a NOP (IF->ID->IF).
REQ-021 Transitions SHALL be as follows:
- IF->ID always.
- ID->IF for j and illegal opcodes.
- ID->HLT for halt.
- ID->EXE for all other opcodes.
- EXE->MEM for lw/sw.
- EXE->IF for beq/bne.
- EXE->WB for R-type and ALU-immediate opcodes.
- MEM->WB for lw; MEM->IF for sw.
- WB->IF always.
- HLT->HLT until reset.
REQ-022 Instruction latency in cycles SHALL be:
- lw: 5
- R-type, ALU-immediate, sw: 4
- beq/bne: 3
- j, illegal: 2
REQ-023 IRWre SHALL be 1 only in IF.
REQ-024 PCWre SHALL be 1 only on the final cycle of each instruction (the cycle whose next state is IF), and SHALL be 0 in HLT.
REQ-025 PCSrc SHALL be:
- 10 in ID for j.
- 01 in EXE for beq with zero=1 or bne with zero=0.
- 00 otherwise.
REQ-026 ALUOp SHALL be:
- 1000 for R-type.
- 0000 for addi, addiu, lw, sw.
- 0010 for andi; 0011 for ori; 0101 for slti.
- 0001 for beq/bne.
- Held constant from ID through the last state of the instruction; 0000 in IF and HLT.
REQ-027 ExtSel SHALL be 0 for andi/ori and 1 otherwise.
REQ-028 RegDst SHALL be 1 only for R-type.
REQ-029 DBDataSrc SHALL be 1 only for lw.
REQ-030 mRD SHALL be 1 only in MEM for lw; mWR SHALL be 1 only in MEM for sw.
REQ-031 RegWre SHALL be 1 only in WB.
REQ-032 retired SHALL increment by 1 on each clock edge at which PCWre=1, and SHALL wrap from all-ones to 0 without saturation.
REQ-033 opcode SHALL be sampled in every state; it is held stable from ID until the next IF because IRWre=0 outside IF.

Reset
REQ-034 While rst_n=0: state=IF, retired=0.
REQ-035 While rst_n=0: PCWre, IRWre, RegWre, mRD, mWR and PCSrc SHALL be forced to 0 regardless of state.
REQ-036 Reset asserted mid-instruction (including in MEM with mWR=1) SHALL deassert all enables immediately and abort the instruction without incrementing retired.
REQ-037 The first rising edge after rst_n rises SHALL see state=IF with IRWre=1.

Verification
REQ-038 Release reset with opcode=000000 -> states IF,ID,EXE,WB,IF; RegWre=1 only in WB; ALUOp=1000; retired=1 after 4 cycles.
REQ-039 opcode=100011 (lw) -> 5-cycle sequence; mRD=1 in MEM; DBDataSrc=1 and RegWre=1 in WB; PCWre=1 only in WB.
REQ-040 opcode=000100 with zero=1, then zero=0 -> PCSrc=01 in EXE on the first run, 00 on the second; 3 cycles each; ALUOp=0001.
REQ-041 opcode=001101 (ori) -> ALUOp=0011, ExtSel=0, RegDst=0.
REQ-042 opcode=000010, then 111111 -> j: PCSrc=10 in ID, 2 cycles; halt: state=111 held 20 cycles, PCWre=0, retired frozen.
REQ-043 Preload retired=FFFF (run 65535 j instructions) then one more -> retired=0000; assert rst_n=0 during MEM of sw -> mWR drops asynchronously, state=IF.
